// File: rtl/rfifo_rd_sched_if.sv
// AXI read address / read data channel bundle between the frame read
// scheduler (master) and the DDR read port (slave).
interface rfifo_rd_sched_if #(
  parameter int ADDR_WIDTH = 28,
  parameter int DATA_WIDTH = 32
);
  // Handshake rule for both channels: a transfer happens on a rising clock
  // edge where valid and ready are both high; a master holds valid and its
  // payload stable until that edge, and ready may change freely.
  logic                  m_arvalid;
  logic                  m_arready;
  logic [ADDR_WIDTH-1:0] m_araddr;
  logic [7:0]            m_arlen;
  logic                  m_rvalid;
  logic                  m_rready;
  logic [DATA_WIDTH-1:0] m_rdata;
  logic                  m_rlast;

  modport master (
    output m_arvalid, m_araddr, m_arlen, m_rready,
    input  m_arready, m_rvalid, m_rdata, m_rlast
  );

  modport slave (
    input  m_arvalid, m_araddr, m_arlen, m_rready,
    output m_arready, m_rvalid, m_rdata, m_rlast
  );
endinterface

// File: rtl/rfifo_rd_sched.sv
// Frame read scheduler: on each frame start it walks the frame buffer with
// fixed-length AXI read bursts, issuing a burst only when the display FIFO
// has room for every beat still in flight, and writes returned beats into
// the FIFO one cycle later.
// Optional feature macro: RD_SCHED_PINGPONG_EN adds the wr_bank input and
// reads the bank the writer does not own (ALT_BASE_ADDR when wr_bank=0).
module rfifo_rd_sched #(
  parameter int                    ADDR_WIDTH       = 28,
  parameter int                    DATA_WIDTH       = 32,
  parameter int                    FIFO_DEPTH_WIDTH = 14,
  parameter int                    BURST_LEN        = 16,
  parameter int                    FRAME_WORDS      = 307200,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR        = '0,
  parameter logic [ADDR_WIDTH-1:0] ALT_BASE_ADDR    = 'h0200000,
  parameter int                    SPACE_MARGIN     = 4
) (
  input  logic                      wr_clk,
  input  logic                      wr_rst,
  input  logic                      frame_start,
`ifdef RD_SCHED_PINGPONG_EN
  input  logic                      wr_bank,
`endif
  input  logic [FIFO_DEPTH_WIDTH:0] wr_water_level,
  output logic                      fifo_wr_en,
  output logic [DATA_WIDTH-1:0]     fifo_wr_data,
  rfifo_rd_sched_if.master          m_axi,
  output logic                      busy,
  output logic                      frame_done,
  output logic                      err_rlast,
  output logic                      err_overrun,
  output logic [1:0]                dbg_state
);

  localparam int NUM_BURSTS  = FRAME_WORDS / BURST_LEN;
  localparam int BURST_BYTES = BURST_LEN * DATA_WIDTH / 8;
  localparam int CNT_W       = $clog2(NUM_BURSTS + 1);
  localparam int BEAT_W      = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int OUT_W       = FIFO_DEPTH_WIDTH + 1;
  localparam int SUM_W       = FIFO_DEPTH_WIDTH + 10;

  localparam logic [CNT_W-1:0]  ALL_BURSTS  = CNT_W'(NUM_BURSTS);
  localparam logic [BEAT_W-1:0] LAST_BEAT   = BEAT_W'(BURST_LEN - 1);
  localparam logic [OUT_W-1:0]  OUT_BURST   = OUT_W'(BURST_LEN);
  localparam logic [SUM_W-1:0]  SPACE_LIMIT =
    (SUM_W'(1) << FIFO_DEPTH_WIDTH) - SUM_W'(SPACE_MARGIN);
  // Index 0 is the primary bank, index 1 the alternate bank.
  localparam logic [1:0][ADDR_WIDTH-1:0] BANK_BASE = {ALT_BASE_ADDR, BASE_ADDR};

  typedef enum logic [1:0] {IDLE, CHECK, REQ, DRAIN} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [CNT_W-1:0]      burst_cnt_q;
  logic [OUT_W-1:0]      outstanding_q;
  logic [BEAT_W-1:0]     beat_idx_q;
  logic                  pending_q;
  logic                  arvalid_q;
  logic                  busy_q;

  logic                  ar_fire;
  logic                  beat_fire;
  logic                  all_issued;
  logic                  last_beat;
  logic                  start_go;
  logic                  space_ok;
  logic [ADDR_WIDTH-1:0] frame_base;

  assign ar_fire    = arvalid_q & m_axi.m_arready;
  // Space is reserved before each request, so every beat is taken on arrival.
  assign beat_fire  = m_axi.m_rvalid & busy_q;
  assign all_issued = (burst_cnt_q == ALL_BURSTS);
  assign last_beat  = beat_fire & all_issued & (outstanding_q == OUT_W'(1));
  assign start_go   = (state_q == IDLE) & (frame_start | pending_q);
  assign space_ok   = (SUM_W'(wr_water_level) + SUM_W'(outstanding_q) +
                       SUM_W'(BURST_LEN)) <= SPACE_LIMIT;

`ifdef RD_SCHED_PINGPONG_EN
  // Read the bank the writer is not using.
  assign frame_base = BANK_BASE[~wr_bank];
`else
  assign frame_base = BANK_BASE[0];
`endif

  assign m_axi.m_arvalid = arvalid_q;
  assign m_axi.m_araddr  = addr_q;
  assign m_axi.m_arlen   = 8'(BURST_LEN - 1);
  assign m_axi.m_rready  = busy_q;
  assign busy            = busy_q;
  assign dbg_state       = state_q;

  // State register.
  always_ff @(posedge wr_clk or posedge wr_rst) begin
    if (wr_rst) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; the final beat of the frame returns to IDLE from any
  // state because it can land while CHECK is still deciding to drain.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_go) state_d = CHECK;
      CHECK: begin
        if (all_issued)    state_d = DRAIN;
        else if (space_ok) state_d = REQ;
      end
      REQ:     if (ar_fire) state_d = CHECK;
      DRAIN:   state_d = DRAIN;
      default: state_d = IDLE;
    endcase
    if (last_beat) state_d = IDLE;
  end

  // Burst address/count, outstanding beats, FIFO write, status and errors.
  always_ff @(posedge wr_clk or posedge wr_rst) begin
    if (wr_rst) begin
      addr_q        <= '0;
      burst_cnt_q   <= '0;
      outstanding_q <= '0;
      beat_idx_q    <= '0;
      pending_q     <= 1'b0;
      arvalid_q     <= 1'b0;
      busy_q        <= 1'b0;
      fifo_wr_en    <= 1'b0;
      fifo_wr_data  <= '0;
      frame_done    <= 1'b0;
      err_rlast     <= 1'b0;
      err_overrun   <= 1'b0;
    end else begin
      arvalid_q  <= (state_d == REQ);
      fifo_wr_en <= beat_fire;
      frame_done <= last_beat;
      if (beat_fire) fifo_wr_data <= m_axi.m_rdata;

      if (start_go) begin
        addr_q      <= frame_base;
        burst_cnt_q <= '0;
        beat_idx_q  <= '0;
        busy_q      <= 1'b1;
        // A start arriving while a pending one is consumed becomes pending.
        pending_q   <= pending_q & frame_start;
      end else begin
        if (ar_fire) begin
          addr_q      <= addr_q + ADDR_WIDTH'(BURST_BYTES);
          burst_cnt_q <= burst_cnt_q + CNT_W'(1);
        end
        if (beat_fire) begin
          beat_idx_q <= (beat_idx_q == LAST_BEAT) ? '0 : beat_idx_q + BEAT_W'(1);
          if (m_axi.m_rlast != (beat_idx_q == LAST_BEAT)) err_rlast <= 1'b1;
        end
        if (last_beat) busy_q <= 1'b0;
        if (busy_q && frame_start) begin
          if (pending_q) err_overrun <= 1'b1;
          else           pending_q   <= 1'b1;
        end
      end

      case ({ar_fire, beat_fire})
        2'b10:   outstanding_q <= outstanding_q + OUT_BURST;
        2'b01:   outstanding_q <= outstanding_q - OUT_W'(1);
        2'b11:   outstanding_q <= outstanding_q + OUT_BURST - OUT_W'(1);
        default: outstanding_q <= outstanding_q;
      endcase
    end
  end

endmodule
